// File: rtl/vga_pkg.sv
// Shared constants, pixel record and FSM state type for the VGA pixel sink.
package vga_pkg;
  localparam int unsigned SCREEN_W_DEF = 320;
  localparam int unsigned SCREEN_H_DEF = 240;
  localparam int unsigned X_W          = 9;
  localparam int unsigned Y_W          = 8;
  localparam int unsigned COLOUR_W     = 3;
  localparam int unsigned ADDR_W       = 17;
  localparam int unsigned PIX_W        = X_W + Y_W + COLOUR_W;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  typedef enum logic [1:0] {IDLE, ADDR, WRITE} state_t;
endpackage

// File: rtl/pixel_fifo.sv
// Power-of-two pixel request buffer; head entry is visible on rd_data.
module pixel_fifo
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  pixel_t                   wr_data,
  input  logic                     pop,
  output pixel_t                   rd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  pixel_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/vga_pixel_sink.sv
// Buffers plot requests and writes them to the framebuffer in order.
// Define PIXEL_CLIP_EN to discard off-screen pixels and count them in dropped.
module vga_pixel_sink
  import vga_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SCREEN_W   = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H   = SCREEN_H_DEF
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [X_W-1:0]      x_in,
  input  logic [Y_W-1:0]      y_in,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                plot,
  output logic                ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [COLOUR_W-1:0] mem_data,
  output logic                mem_we,
  input  logic                mem_ack,
  output logic                busy,
  output logic [7:0]          dropped
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      SCREEN_W * SCREEN_H > (1 << ADDR_W)) begin : g_param_chk
    $error("vga_pixel_sink: unsupported FIFO_DEPTH or screen size");
  end

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic              clipped;
  pixel_t            pix_in;
  pixel_t            head;
  pixel_t            cur;
  logic [ADDR_W-1:0] addr_calc;

  assign pix_in = '{x: x_in, y: y_in, colour: colour_in};
  assign ready  = count < CNT_W'(FIFO_DEPTH);
  assign push   = plot && ready;
  assign busy   = (count != '0) || (state != IDLE);

  pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (push),
    .wr_data (pix_in),
    .pop     (pop),
    .rd_data (head),
    .count   (count)
  );

  // 320 = 256 + 64, so the row offset is two shifted copies of y.
  if (SCREEN_W == 320) begin : g_addr_shift
    assign addr_calc = ADDR_W'({cur.y, 8'b0}) + ADDR_W'({cur.y, 6'b0}) + ADDR_W'(cur.x);
  end else begin : g_addr_mul
    assign addr_calc = ADDR_W'(ADDR_W'(cur.y) * ADDR_W'(SCREEN_W)) + ADDR_W'(cur.x);
  end

`ifdef PIXEL_CLIP_EN
  assign clipped = (32'(cur.x) >= SCREEN_W) || (32'(cur.y) >= SCREEN_H);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      dropped <= '0;
    else if (state == ADDR && clipped && dropped != '1)
      dropped <= dropped + 8'd1;
  end
`else
  assign clipped = 1'b0;
  assign dropped = '0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (count != '0) state_nx = ADDR;
      ADDR:    state_nx = clipped ? IDLE : WRITE;
      WRITE:   if (mem_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pop    = (state == IDLE) && (count != '0);
    mem_we = (state == WRITE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur      <= '0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      if (pop) cur <= head;
      if (state == ADDR && !clipped) begin
        mem_addr <= addr_calc;
        mem_data <= cur.colour;
      end
    end
  end
endmodule
